// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous shadowing of the displayed digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    output logic [6:0]              codeout,
    output logic [NUM_DIGITS-1:0]   seg,
    output logic                    frame_stb
);
    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;
    logic                    tick;
    logic                    boundary;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   seg_nxt;
    logic [6:0]              code_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign tick     = en && (presc == PRESC_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (en) begin
            if (tick) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Active digits only change on the frame boundary; a load on that very cycle bypasses pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                active <= bcd;
            end else if (pending_valid) begin
                active <= pending;
            end
            pending_valid <= 1'b0;
        end else if (load) begin
            pending       <= bcd;
            pending_valid <= 1'b1;
        end
    end

    always_comb begin
        cur_digit = '0;
        seg_nxt   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit  = active[4*i +: 4];
                seg_nxt[i] = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;

    // blank[i] is set when digit i and every digit above it are zero.
    always_comb begin : lz_mask
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (active[4*i +: 4] == 4'd0);
            blank[i]   = upper_zero;
        end
    end

    assign code_nxt = (|(blank & seg_nxt)) ? 7'd0 : decode(cur_digit);
`else
    assign code_nxt = decode(cur_digit);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg       <= '0;
            codeout   <= '0;
            frame_stb <= 1'b0;
        end else if (!en) begin
            seg       <= '0;
            codeout   <= '0;
            frame_stb <= 1'b0;
        end else begin
            seg       <= seg_nxt;
            codeout   <= code_nxt;
            frame_stb <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (SCAN_DIV=4 and SCAN_DIV=1) share stimulus;
// a count-based reference model predicts outputs, a monitor pops and compares every cycle.
module tb_seg7_scan_driver;
    typedef struct packed {
        logic [3:0] seg;
        logic [6:0] code;
        logic       stb;
    } exp_t;

    localparam int DIV [2] = '{4, 1};
    localparam logic [6:0] DEC [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
        7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd = 16'h0;
    logic [6:0]  code0, code1;
    logic [3:0]  seg0, seg1;
    logic        stb0, stb1;

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd(bcd),
        .codeout(code0), .seg(seg0), .frame_stb(stb0));

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd(bcd),
        .codeout(code1), .seg(seg1), .frame_stb(stb1));

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int          ecount [2];
    logic [15:0] act [2];
    logic [15:0] pend [2];
    bit          pv [2];

    task automatic check(input string name, input exp_t got, input exp_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t got seg=%b code=%b stb=%b expected seg=%b code=%b stb=%b",
                     name, $time, got.seg, got.code, got.stb, want.seg, want.code, want.stb);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ecount[k] = 0;
            act[k]    = 16'h0;
            pend[k]   = 16'h0;
            pv[k]     = 1'b0;
        end
    endtask

    // Digit position follows from the number of enabled cycles; a frame ends every 4*DIV of them.
    task automatic model_step(input int k, output exp_t e);
        int         d;
        int         pos;
        bit         bnd;
        logic [3:0] nib;
        d   = DIV[k];
        pos = (ecount[k] / d) % 4;
        nib = act[k][4*pos +: 4];
        e.seg  = en ? 4'(1 << pos) : 4'd0;
        e.code = en ? DEC[nib] : 7'd0;
`ifdef LEADING_ZERO_BLANK_EN
        if (en && pos > 0 && (act[k] >> (4*pos)) == 16'h0) e.code = 7'd0;
`endif
        bnd   = en && ((ecount[k] + 1) % (4*d) == 0);
        e.stb = bnd;
        if (bnd) begin
            if (load) act[k] = bcd;
            else if (pv[k]) act[k] = pend[k];
            pv[k] = 1'b0;
        end else if (load) begin
            pend[k] = bcd;
            pv[k]   = 1'b1;
        end
        if (en) ecount[k]++;
    endtask

    task automatic step(input logic e_i, input logic l_i, input logic [15:0] b_i);
        exp_t e;
        @(negedge clk);
        en   = e_i;
        load = l_i;
        bcd  = b_i;
        model_step(0, e);
        q0.push_back(e);
        model_step(1, e);
        q1.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dut0"}, {seg0, code0, stb0}, '0);
        check({tag, "_dut1"}, {seg1, code1, stb1}, '0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) check("dut0", {seg0, code0, stb0}, q0.pop_front());
            if (q1.size() > 0) check("dut1", {seg1, code1, stb1}, q1.pop_front());
        end
    end

    initial begin : stimulus
        logic [15:0] r;
        logic        re, rl;
        int          guard;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("power_on_reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 1, 16'h1778);
        repeat (40) step(1, 0, 16'h0);

        guard = 0;
        while (((ecount[0] / 4) % 4) != 2 && guard < 20) begin
            step(1, 0, 16'h0);
            guard++;
        end
        step(1, 1, 16'h1234);
        repeat (24) step(1, 0, 16'h0);

        step(1, 1, 16'h0005);
        step(1, 1, 16'h0009);
        repeat (24) step(1, 0, 16'h0);

        guard = 0;
        while (((ecount[0] + 1) % 16) != 0 && guard < 20) begin
            step(1, 0, 16'h0);
            guard++;
        end
        step(1, 1, 16'h4321);
        repeat (20) step(1, 0, 16'h0);

        step(1, 1, 16'h9C3C);
        repeat (18) step(1, 0, 16'h0);
        repeat (10) step(0, 0, 16'h0);
        repeat (20) step(1, 0, 16'h0);

        step(1, 1, 16'h0040);
        repeat (36) step(1, 0, 16'h0);
        step(1, 1, 16'h0000);
        repeat (36) step(1, 0, 16'h0);

        step(0, 1, 16'h0780);
        repeat (20) step(1, 0, 16'h0);

        step(1, 1, 16'h8888);
        repeat (3) step(1, 0, 16'h0);
        mid_reset();
        repeat (40) step(1, 0, 16'h0);

        repeat (800) begin
            r  = 16'($urandom) >> (4 * $urandom_range(0, 3));
            re = ($urandom_range(0, 7) != 0);
            rl = ($urandom_range(0, 9) == 0);
            step(re, rl, r);
        end
        mid_reset();
        repeat (200) begin
            r  = 16'($urandom) >> (4 * $urandom_range(0, 3));
            re = ($urandom_range(0, 5) != 0);
            rl = ($urandom_range(0, 4) == 0);
            step(re, rl, r);
        end

        @(negedge clk);
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending entries dut0=%0d dut1=%0d expected 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
